// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - decode-stage control unit with registered ID/EX word, load-use stall and flush
//
// Purpose: decodes the opcode of each presented instruction and captures the
// control word plus register fields into the ID/EX register. It uses a
// valid/ready handshake on both sides. It inserts one bubble when a load is
// followed by a dependent instruction. A synchronous flush kills both the
// ID/EX word and the instruction being presented.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   if_valid, inst        presented instruction and its valid flag
//   id_ready              instruction accepted this cycle (combinational)
//   ex_ready, ex_flush    execute-stage backpressure and kill
//   ex_valid, ex_*        registered control word and register fields
//   ex_illegal            current word came from the reserved opcode
//   illegal_seen          sticky flag for any accepted reserved opcode
//   stall_count           saturating count of load-use bubbles
module pipelined_control_unit #(
    parameter int INST_W      = 16,
    parameter int OPC_W       = 3,
    parameter int REG_W       = 3,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    input  logic [INST_W-1:0]      inst,
    output logic                   id_ready,
    input  logic                   ex_ready,
    input  logic                   ex_flush,
    output logic                   ex_valid,
    output logic                   ex_WB_ALUtoReg,
    output logic                   ex_RegWrite,
    output logic                   ex_MemRead,
    output logic                   ex_MemWrite,
    output logic [1:0]             ex_ALUOp,
    output logic [1:0]             ex_carrySelect,
    output logic [REG_W-1:0]       ex_ra,
    output logic [REG_W-1:0]       ex_rb,
    output logic                   ex_illegal,
    output logic                   illegal_seen,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic {S_RUN, S_STALL} state_t;
    state_t state, state_next;

    logic [2:0]       op3;
    logic [REG_W-1:0] ra_in, rb_in;
    logic             unused_bits;

    // Only the top three opcode bits select a decode row.
    assign op3         = inst[INST_W-1 -: 3];
    assign ra_in       = inst[INST_W-OPC_W-1 -: REG_W];
    assign rb_in       = inst[INST_W-OPC_W-REG_W-1 -: REG_W];
    assign unused_bits = ^inst;

    logic       d_wb, d_rw, d_mr, d_mw, d_ill, use_ra, use_rb;
    logic [1:0] d_alu, d_cs;

    always_comb begin
        d_wb   = 1'b0;
        d_rw   = 1'b0;
        d_mr   = 1'b0;
        d_mw   = 1'b0;
        d_alu  = 2'b00;
        d_cs   = 2'b00;
        d_ill  = 1'b0;
        use_ra = 1'b0;
        use_rb = 1'b0;
        case (op3)
            3'b001: d_rw = 1'b1;                                        // LDM
            3'b010: begin d_mw = 1'b1; d_alu = 2'b10;                   // STD
                          use_ra = 1'b1; use_rb = 1'b1; end
            3'b011: begin d_wb = 1'b1; d_rw = 1'b1; d_cs = 2'b10;       // ADD
                          use_ra = 1'b1; use_rb = 1'b1; end
            3'b100: begin d_wb = 1'b1; d_rw = 1'b1; d_alu = 2'b01;      // NOT
                          use_ra = 1'b1; end
            3'b101: d_alu = 2'b11;                                      // NOP
            3'b110: begin d_rw = 1'b1; d_mr = 1'b1; d_alu = 2'b10;      // LDD: ra is the destination
                          use_rb = 1'b1; end
            3'b111: d_ill = 1'b1;                                       // reserved
            default: ;                                                  // bubble
        endcase
    end

    // A load in EX writes ex_ra; any decoded source matching it must wait a cycle.
    logic hazard, hold;
    assign hazard = (state == S_RUN) && ex_valid && ex_MemRead && if_valid &&
                    ((use_ra && (ra_in == ex_ra)) || (use_rb && (rb_in == ex_ra)));
    assign hold   = ex_valid && !ex_ready;

    logic do_flush, do_stall, do_load;

    always_comb begin
        state_next = state;
        id_ready   = 1'b1;
        do_flush   = 1'b0;
        do_stall   = 1'b0;
        do_load    = 1'b0;
        if (ex_flush) begin
            do_flush   = 1'b1;
            state_next = S_RUN;
        end else if (hold) begin
            id_ready   = 1'b0;
        end else if (hazard) begin
            id_ready   = 1'b0;
            do_stall   = 1'b1;
            state_next = S_STALL;
        end else begin
            do_load    = 1'b1;
            state_next = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_RUN;
            ex_valid       <= 1'b0;
            ex_WB_ALUtoReg <= 1'b0;
            ex_RegWrite    <= 1'b0;
            ex_MemRead     <= 1'b0;
            ex_MemWrite    <= 1'b0;
            ex_ALUOp       <= 2'b00;
            ex_carrySelect <= 2'b00;
            ex_ra          <= '0;
            ex_rb          <= '0;
            ex_illegal     <= 1'b0;
            illegal_seen   <= 1'b0;
            stall_count    <= '0;
        end else begin
            state <= state_next;
            if (do_flush || do_stall || (do_load && !if_valid)) begin
                ex_valid       <= 1'b0;
                ex_WB_ALUtoReg <= 1'b0;
                ex_RegWrite    <= 1'b0;
                ex_MemRead     <= 1'b0;
                ex_MemWrite    <= 1'b0;
                ex_ALUOp       <= 2'b00;
                ex_carrySelect <= 2'b00;
                ex_ra          <= '0;
                ex_rb          <= '0;
                ex_illegal     <= 1'b0;
            end else if (do_load) begin
                ex_valid       <= 1'b1;
                ex_WB_ALUtoReg <= d_wb;
                ex_RegWrite    <= d_rw;
                ex_MemRead     <= d_mr;
                ex_MemWrite    <= d_mw;
                ex_ALUOp       <= d_alu;
                ex_carrySelect <= d_cs;
                ex_ra          <= ra_in;
                ex_rb          <= rb_in;
                ex_illegal     <= d_ill;
            end
            if (do_load && if_valid && d_ill)
                illegal_seen <= 1'b1;
            if (do_stall && (stall_count != {STALL_CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Registered, parametrised successor to the decode-stage control unit. It decodes the opcode field of each instruction and captures the control word plus register fields into an ID/EX pipeline register. It uses a valid/ready handshake on both sides, inserts one bubble on a load-use hazard, and supports a synchronous flush. It sits between the fetch/decode register and the execute stage.

## Interface
- INST_W, 16, instruction width
- OPC_W, 3, opcode width; opcode = inst[INST_W-1 -: OPC_W]
- REG_W, 3, register-address width; ra = inst[INST_W-OPC_W-1 -: REG_W], rb = the next REG_W bits below ra
- STALL_CNT_W, 8, width of the saturating stall counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  inst holds a valid instruction
- inst  in  INST_W  instruction from decode
- id_ready  out  1  instruction accepted this cycle (combinational)
- ex_ready  in  1  execute stage can take the current ex_* word
- ex_flush  in  1  kill the ID/EX contents and the presented instruction
- ex_valid  out  1  ex_* word is valid
- ex_WB_ALUtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite  out  1 each  registered control bits
- ex_ALUOp  out  2  ALU operation
- ex_carrySelect  out  2  carry-flag source
- ex_ra, ex_rb  out  REG_W  register fields
- ex_illegal  out  1  the current word came from a reserved opcode
- illegal_seen  out  1  sticky; set by any accepted reserved opcode
- stall_count  out  STALL_CNT_W  load-use bubbles inserted, saturating

## Operation
- Decode table, listed as WB_ALUtoReg / RegWrite / MemRead / MemWrite / ALUOp / carrySelect. No x values are driven; don't-cares are driven as 0.
  - 001 LDM: 0/1/0/0/00/00; sources none
  - 010 STD: 0/0/0/1/10/00; sources ra, rb
  - 011 ADD: 1/1/0/0/00/10; sources ra, rb
  - 100 NOT: 1/1/0/0/01/00; sources ra
  - 101 NOP: 0/0/0/0/11/00; sources none
  - 110 LDD: 0/1/1/0/10/00; destination ra; sources rb
  - 000 bubble: all zero; sources none
  - 111 reserved: all zero; ex_illegal=1; sources none
- For OPC_W>3, only the top 3 opcode bits select a row. Lower opcode bits are ignored.
- Hazard: asserted when ex_valid=1, ex_MemRead=1, if_valid=1, and one of the decoded sources equals ex_ra.
- FSM states:
  - RUN: on hazard (no flush, ex_ready=1), load a bubble (ex_valid<=0), hold id_ready=0, increment stall_count, go to STALL.
  - STALL: hazard cannot recur because ex_MemRead is now 0. Accept normally and go to RUN.
- Per-edge priority:
  1. reset
  2. ex_flush: ex_valid<=0, ex_illegal<=0, state<=RUN. id_ready=1 and the presented instruction is discarded.
  3. ex_valid=1 and ex_ready=0: hold all ex_* outputs, id_ready=0.
  4. hazard: bubble as described above.
  5. load: ex_valid<=if_valid. Control bits, ex_ra, ex_rb and ex_illegal load from the decode. When if_valid=0, load a bubble.
- id_ready is combinational: 1 unless case 3 or case 4 applies.
- illegal_seen sets on any accepted 111 instruction that is not flushed. It is cleared only by reset.
- stall_count saturates at all ones. It does not increment on flush or hold cycles.

## Timing
- Latency: an instruction accepted at edge N is visible on ex_* after edge N. One per cycle without stalls.
- A load-use pair costs exactly one bubble cycle. Back-to-back LDD instructions with a dependency each cost one bubble.
- Reset (asynchronous, mid-operation included): every output is 0 and state=RUN immediately. id_ready follows its equation after reset.
- Simultaneous ex_flush and hazard: flush wins; no bubble is counted.
- Simultaneous ex_flush and ex_ready=0: flush wins and the contents are cleared.
- While ex_valid=0, ex_ready is ignored.

## Test plan
- Reset, then stream 2400, 2802, 6500, 8400, 4500, all with ex_ready=1.
  - Expect ex_valid each cycle, one cycle late.
  - For 6500: RegWrite=1, WB_ALUtoReg=1, ALUOp=00, carrySelect=10, ra=1, rb=2.
  - For 4500: MemWrite=1, ALUOp=10.
- LDD with ra=1 (C400), then ADD 6500.
  - Expect id_ready=0 for exactly one cycle and one ex_valid=0 bubble.
  - The ADD appears two edges after the LDD; stall_count=1.
- LDD (C400), then NOT R2 (8800), which has no dependency.
  - Expect no stall and stall_count unchanged.
- Hold ex_ready=0 for 3 cycles with 6500 in EX.
  - Expect ex_* stable and id_ready=0; the next instruction appears one edge after ex_ready rises.
- Assert ex_flush during a load-use hazard.
  - Expect ex_valid=0 next cycle, stall_count unchanged, state RUN.
- Send opcode E000, then NOP A000; also pulse rst_n low mid-stream.
  - E000: ex_illegal=1 with all control bits 0, and illegal_seen remains 1.
  - A000: ALUOp=11.
  - On the reset pulse, all outputs go to 0 without waiting for a clock edge.
